// File: rtl/key_pulse_pkg.sv
// Shared state encoding and default timing for the key_pulse press/auto-repeat
// strobe generator.
package key_pulse_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] REPEAT  = 2'd2;

  localparam int HOLD_CYCLES_DEF   = 50_000_000;
  localparam int REPEAT_CYCLES_DEF = 10_000_000;
  localparam int CNT_W_DEF         = 26;

endpackage

// File: rtl/key_pulse.sv
// Turns a debounced key level into a press strobe, timed auto-repeat strobes,
// a release strobe, a held flag and a running press count.
//
// state   | meaning
// IDLE    | key up, waiting for a press
// PRESSED | key down, timing the hold delay before auto-repeat
// REPEAT  | key still down, issuing a strobe every REPEAT_CYCLES
import key_pulse_pkg::*;

module key_pulse #(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ds,
  output logic       pulse,
  output logic       rel_pulse,
  output logic       held,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pulse_nxt, rel_nxt, held_nxt;

  // Release is tested before terminal count so a release on the terminal
  // cycle yields only rel_pulse.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    rel_nxt   = 1'b0;
    held_nxt  = held;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        held_nxt = 1'b0;
        if (ds) begin
          state_nxt = PRESSED;
          pulse_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (!ds) begin
          state_nxt = IDLE;
          rel_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_TC) begin
          state_nxt = REPEAT;
          pulse_nxt = 1'b1;
          held_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!ds) begin
          state_nxt = IDLE;
          rel_nxt   = 1'b1;
          held_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else if (cnt == REPEAT_TC) begin
          pulse_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        held_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pulse     <= 1'b0;
      rel_pulse <= 1'b0;
      held      <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pulse     <= pulse_nxt;
      rel_pulse <= rel_nxt;
      held      <= held_nxt;
      if (pulse_nxt) press_cnt <= press_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_key_pulse.sv
// Directed bench for key_pulse with short hold/repeat timing; expected outputs
// are queued as each step is driven and checked after the following edge.
module tb_key_pulse;
  import key_pulse_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ds = 1'b0;
  logic       pulse, rel_pulse, held;
  logic [7:0] press_cnt;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [10:0] sb[$];
  logic       mon_en = 1'b0;
  logic       pulse_q = 1'b0;

  key_pulse #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ds       (ds),
    .pulse    (pulse),
    .rel_pulse(rel_pulse),
    .held     (held),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  // One clock: drive reset/ds, queue the outputs expected after the edge.
  task automatic step(input logic r, input logic d, input logic ep,
                      input logic er, input logic eh, input string tag);
    logic [10:0] exp_v, obs_v;
    @(negedge clk);
    reset = r;
    ds    = d;
    if (r) exp_cnt = 8'd0;
    else if (ep) exp_cnt = exp_cnt + 8'd1;
    sb.push_back({ep, er, eh, exp_cnt});
    @(posedge clk);
    #1;
    obs_v = {pulse, rel_pulse, held, press_cnt};
    exp_v = sb.pop_front();
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed pulse=%b rel=%b held=%b cnt=%0d expected pulse=%b rel=%b held=%b cnt=%0d",
             tag, obs_v[10], obs_v[9], obs_v[8], obs_v[7:0],
             exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
    end
  endtask

  // Continuous output invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert (!(pulse && rel_pulse)) else begin
        errors++;
        $error("FAIL overlap: observed pulse=%b rel=%b expected not both 1", pulse, rel_pulse);
      end
      checks++;
      assert (!(pulse && pulse_q)) else begin
        errors++;
        $error("FAIL double_pulse: observed pulse=1 twice expected single-cycle strobe");
      end
      checks++;
      assert (!(held && dut.state == IDLE)) else begin
        errors++;
        $error("FAIL held_idle: observed held=%b in IDLE expected 0", held);
      end
    end
    pulse_q = pulse;
  end

  initial begin
    // Reset, including ds high while reset is asserted
    step(1, 0, 0, 0, 0, "reset0");
    step(1, 1, 0, 0, 0, "reset1");
    mon_en = 1'b1;
    step(0, 0, 0, 0, 0, "idle0");
    step(0, 0, 0, 0, 0, "idle1");

    // Short press
    step(0, 1, 1, 0, 0, "short_rise");
    step(0, 1, 0, 0, 0, "short_hold1");
    step(0, 1, 0, 0, 0, "short_hold2");
    step(0, 0, 0, 1, 0, "short_rel");
    step(0, 0, 0, 0, 0, "short_idle");

    // Long press: pulses at 0, 8, 12, 16; release lands on repeat terminal count
    for (int i = 0; i < 20; i++)
      step(0, 1, (i == 0 || i == 8 || i == 12 || i == 16), 0, (i >= 8), "long_hold");
    step(0, 0, 0, 1, 0, "long_rel_tc");
    step(0, 0, 0, 0, 0, "long_idle");

    // Release on the hold terminal count in PRESSED
    for (int i = 0; i < 8; i++)
      step(0, 1, (i == 0), 0, 0, "hold_tc_press");
    step(0, 0, 0, 1, 0, "hold_tc_rel");
    step(0, 0, 0, 0, 0, "hold_tc_idle");

    // Release mid-repeat (not on terminal count)
    for (int i = 0; i < 10; i++)
      step(0, 1, (i == 0 || i == 8), 0, (i >= 8), "mid_rep_press");
    step(0, 0, 0, 1, 0, "mid_rep_rel");
    step(0, 0, 0, 0, 0, "mid_rep_idle");

    // Reset during REPEAT with ds held high: no release strobe, new press after
    for (int i = 0; i < 10; i++)
      step(0, 1, (i == 0 || i == 8), 0, (i >= 8), "rst_rep_press");
    step(1, 1, 0, 0, 0, "rst_rep_reset");
    step(0, 1, 1, 0, 0, "rst_rep_repress");
    step(0, 1, 0, 0, 0, "rst_rep_hold");
    step(0, 0, 0, 1, 0, "rst_rep_rel");

    // Counter wrap: 257 short presses from zero
    step(1, 0, 0, 0, 0, "wrap_reset");
    for (int i = 0; i < 257; i++) begin
      step(0, 1, 1, 0, 0, "wrap_press");
      step(0, 0, 0, 1, 0, "wrap_rel");
    end
    checks++;
    assert (press_cnt === 8'h01) else begin
      errors++;
      $error("FAIL wrap_final: observed press_cnt=%0h expected 01", press_cnt);
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_pulse.md
KEY_PULSE -- requirements
Module: key_pulse

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000; number of cycles `ds` must stay high after a press before auto-repeat starts.
REQ-002 Parameter REPEAT_CYCLES, default 10_000_000; period in cycles between auto-repeat pulses.
REQ-003 Parameter CNT_W, default 26; width of the internal cycle counter; SHALL satisfy 2^CNT_W >= max(HOLD_CYCLES, REPEAT_CYCLES).
REQ-004 clk  input  1  single system clock; all logic SHALL sample on its rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 ds  input  1  debounced, synchronized key level from the upstream synchronizer; already in the clk domain.
REQ-007 pulse  output  1  one-cycle strobe per press and per auto-repeat.
REQ-008 rel_pulse  output  1  one-cycle strobe on key release.
REQ-009 held  output  1  high while the key is in the auto-repeat phase.
REQ-010 press_cnt  output  8  count of `pulse` strobes issued since reset; wraps 8'hFF -> 8'h00.

Function
REQ-011 All outputs SHALL be registered; there SHALL be no combinational path from `ds` to any output.
REQ-012 FSM states SHALL be exactly IDLE, PRESSED and REPEAT.
REQ-013 IDLE with ds=1 at an edge: go to PRESSED, cnt<=0, pulse=1 for the following cycle (latency one clk from the first high sample).
REQ-014 IDLE with ds=0: stay in IDLE; all strobes low.
REQ-015 PRESSED with ds=0: go to IDLE, rel_pulse=1 for one cycle, cnt<=0.
REQ-016 PRESSED with ds=1 and cnt==HOLD_CYCLES-1: go to REPEAT, pulse=1, held<=1, cnt<=0.
REQ-017 PRESSED with ds=1 otherwise: cnt<=cnt+1.
REQ-018 REPEAT with ds=0: go to IDLE, rel_pulse=1, held<=0, cnt<=0.
REQ-019 REPEAT with ds=1 and cnt==REPEAT_CYCLES-1: pulse=1, cnt<=0, stay in REPEAT.
REQ-020 REPEAT with ds=1 otherwise: cnt<=cnt+1.
REQ-021 Simultaneous ds=0 and terminal count: release wins; no pulse is issued, only rel_pulse.
REQ-022 pulse and rel_pulse SHALL never be high in the same cycle.
REQ-023 press_cnt SHALL increment in the same cycle that pulse is registered high, and wrap at 8 bits with no saturation.
REQ-024 cnt SHALL never exceed max(HOLD_CYCLES, REPEAT_CYCLES)-1.

Reset
REQ-025 reset=1 at an edge SHALL force state IDLE, cnt=0, pulse=0, rel_pulse=0, held=0, press_cnt=0; reset takes priority over all transitions.
REQ-026 Reset mid-press (PRESSED or REPEAT) SHALL NOT generate rel_pulse.
REQ-027 If ds=1 at the first edge after reset deasserts, the block SHALL treat it as a new press (REQ-013).

Structure
REQ-028 Package key_pulse_pkg SHALL hold the state encoding (IDLE=2'd0, PRESSED=2'd1, REPEAT=2'd2) and the default HOLD_CYCLES and REPEAT_CYCLES constants.
REQ-029 The block SHALL be a single module with no sub-modules; the counter and FSM are inline.
REQ-030 In the top level, the block SHALL sit directly downstream of the key synchronizer, with `ds` driven by that synchronizer's output.
REQ-031 Unused encoding 2'd3 SHALL recover to IDLE on the next edge.

Verification (bench uses HOLD_CYCLES=8, REPEAT_CYCLES=4)
REQ-032 Short press: ds high for 3 cycles, then low -> exactly one pulse 1 cycle after the rise, one rel_pulse 1 cycle after the fall, held never high, press_cnt=1.
REQ-033 Long press: ds high for 20 cycles -> pulses at cycles 1, 9, 13, 17 after the rise; held high from cycle 9 until 1 cycle after the fall; press_cnt=4.
REQ-034 Release on terminal count: ds falls in the cycle where REPEAT cnt==3 -> no pulse, rel_pulse=1, held=0 next cycle.
REQ-035 Reset during REPEAT with ds still high: all outputs 0 the cycle after reset; after reset deasserts with ds=1, pulse=1 after 1 cycle, press_cnt=1, no rel_pulse at any point.
REQ-036 Wrap: 256 short presses -> press_cnt returns to 8'h00; 257th press -> press_cnt=8'h01.
REQ-037 Assertions throughout: pulse&rel_pulse never high together; pulse never high for 2 consecutive cycles; held never high in IDLE.
